dmem_bank_hs: RTL and testbench

//  Parametrised data memory with a req/ready handshake, programmable wait states and MIPS

---
 rtl/dmem_bank_hs.sv | 158 +++++++++++++++
 tb/tb_dmem_bank_hs.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_bank_hs.sv
// dmem_bank_hs: word-organised data memory behind a req/ready handshake with programmable
// wait states and MIPS byte/half/word access. Define DMEM_INIT_EN to preload word i = i*10.
module dmem_bank_hs #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_t              state, next_state;
    logic [3:0]          cnt;
    logic                enter_resp;

    logic                lat_we, lat_uns;
    logic [1:0]          lat_size;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic                acc_we, acc_uns, acc_misalign;
    logic [1:0]          acc_size;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [ADDR_W-3:0]   acc_idx;
    logic [DATA_W-1:0]   cur_word, load_val, store_word;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;

    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef DMEM_INIT_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_W'(i * 10);
        end
    end
`else
`endif

    always_comb begin
        next_state = state;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    enter_resp = (WAIT_STATES == 0);
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // In IDLE the access is taken straight from the inputs (zero-wait case); later from the latches.
    always_comb begin
        if (state == S_IDLE) begin
            acc_we    = we;
            acc_uns   = uns;
            acc_size  = size;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else begin
            acc_we    = lat_we;
            acc_uns   = lat_uns;
            acc_size  = lat_size;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
        end
    end

    always_comb begin
        acc_idx      = acc_addr[ADDR_W-1:2];
        cur_word     = mem[acc_idx];
        acc_misalign = ((acc_size == 2'b01) && acc_addr[0]) ||
                       (acc_size[1] && (acc_addr[1:0] != 2'b00));
        byte_v       = cur_word[{acc_addr[1:0], 3'b000} +: 8];
        half_v       = cur_word[{acc_addr[1], 4'b0000} +: 16];
        load_val     = cur_word;
        store_word   = cur_word;
        case (acc_size)
            2'b00: begin
                load_val = {{24{~acc_uns & byte_v[7]}}, byte_v};
                store_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
            end
            2'b01: begin
                load_val = {{16{~acc_uns & half_v[15]}}, half_v};
                store_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
            end
            default: begin
                load_val   = cur_word;
                store_word = acc_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ready     <= 1'b0;
            rdata     <= '0;
            misalign  <= 1'b0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= next_state;
            ready <= (state == S_RESP);
            if ((state == S_IDLE) && req) begin
                cnt       <= WAIT_CNT;
                lat_we    <= we;
                lat_uns   <= uns;
                lat_size  <= size;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                misalign <= acc_misalign;
                rdata    <= (acc_we || acc_misalign) ? '0 : load_val;
            end
        end
    end

    // The merged word is committed while leaving RESP so the array needs no reset term;
    // nothing can read the word before the next acceptance, so the effect is identical.
    always_ff @(posedge clk) begin
        if ((state == S_RESP) && lat_we && !misalign) begin
            mem[acc_idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_dmem_bank_hs.sv
// tb_dmem_bank_hs: directed checks of dmem_bank_hs with one instance at 1 wait state and
// one at 3 wait states; memory is written by the bench before any read.
module tb_dmem_bank_hs;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req1, req3;
    logic        we, uns;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        ready1, ready3, misalign1, misalign3;
    logic [31:0] rdata1, rdata3;

    int total = 0;
    int bad   = 0;

    dmem_bank_hs #(.DATA_W(32), .DEPTH(128), .ADDR_W(9), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready1), .rdata(rdata1), .misalign(misalign1)
    );

    dmem_bank_hs #(.DATA_W(32), .DEPTH(128), .ADDR_W(9), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready3), .rdata(rdata3), .misalign(misalign3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One handshake: raise req, wait (bounded) for ready, report latency in edges after acceptance.
    task automatic applyStimulus(input logic sel3, input logic w, input logic [1:0] sz,
                                 input logic u, input logic [8:0] a, input logic [31:0] d,
                                 output int lat, output logic [31:0] rd, output logic mis);
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = d;
        if (sel3) req3 = 1'b1;
        else      req1 = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!(sel3 ? ready3 : ready1) && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd   = sel3 ? rdata3 : rdata1;
        mis  = sel3 ? misalign3 : misalign1;
        req1 = 1'b0;
        req3 = 1'b0;
    endtask

    task automatic doAccess(input string tag, input logic sel3, input logic w, input logic [1:0] sz,
                            input logic u, input logic [8:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_mis);
        int          lat;
        logic [31:0] rd;
        logic        mis;
        applyStimulus(sel3, w, sz, u, a, d, lat, rd, mis);
        checkOutput({tag, "_lat"}, 32'(lat), sel3 ? 32'd4 : 32'd2);
        checkOutput({tag, "_rdata"}, rd, exp_rd);
        checkOutput({tag, "_misalign"}, {31'b0, mis}, {31'b0, exp_mis});
    endtask

    initial begin
        int pulses, first, second, cyc;

        reset = 1'b1; req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; uns = 1'b0; size = SZ_W; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready1", {31'b0, ready1}, 32'd0);
        checkOutput("rst_rdata1", rdata1, 32'd0);
        checkOutput("rst_misalign1", {31'b0, misalign1}, 32'd0);
        checkOutput("rst_ready3", {31'b0, ready3}, 32'd0);
        reset = 1'b0;

        $display("[TB] latency and word load");
        doAccess("t1_sw", 1'b0, 1'b1, SZ_W, 1'b0, 9'h014, 32'h0000_0032, 32'h0, 1'b0);
        doAccess("t1_lw", 1'b0, 1'b0, SZ_W, 1'b0, 9'h014, 32'h0, 32'h0000_0032, 1'b0);
        @(negedge clk);
        checkOutput("t1_pulse_width", {31'b0, ready1}, 32'd0);

        $display("[TB] sub-word loads");
        doAccess("t2_sw",  1'b0, 1'b1, SZ_W, 1'b0, 9'h008, 32'hDEAD_BEEF, 32'h0, 1'b0);
        doAccess("t2_lb",  1'b0, 1'b0, SZ_B, 1'b0, 9'h00B, 32'h0, 32'hFFFF_FFDE, 1'b0);
        doAccess("t2_lbu", 1'b0, 1'b0, SZ_B, 1'b1, 9'h00B, 32'h0, 32'h0000_00DE, 1'b0);
        doAccess("t2_lh",  1'b0, 1'b0, SZ_H, 1'b0, 9'h008, 32'h0, 32'hFFFF_BEEF, 1'b0);
        doAccess("t2_lhu", 1'b0, 1'b0, SZ_H, 1'b1, 9'h00A, 32'h0, 32'h0000_DEAD, 1'b0);

        $display("[TB] byte store merge");
        doAccess("t3_sb", 1'b0, 1'b1, SZ_B, 1'b0, 9'h009, 32'h0000_007F, 32'h0, 1'b0);
        doAccess("t3_lw", 1'b0, 1'b0, SZ_W, 1'b0, 9'h008, 32'h0, 32'hDEAD_7FEF, 1'b0);
        doAccess("t3_lb_pos", 1'b0, 1'b0, SZ_B, 1'b0, 9'h009, 32'h0, 32'h0000_007F, 1'b0);

        $display("[TB] misaligned accesses");
        doAccess("t4_sw0", 1'b0, 1'b1, SZ_W, 1'b0, 9'h000, 32'h1122_3344, 32'h0, 1'b0);
        doAccess("t4_sw4", 1'b0, 1'b1, SZ_W, 1'b0, 9'h004, 32'h5566_7788, 32'h0, 1'b0);
        doAccess("t4_lw_mis", 1'b0, 1'b0, SZ_W, 1'b0, 9'h002, 32'h0, 32'h0, 1'b1);
        doAccess("t4_sh_mis", 1'b0, 1'b1, SZ_H, 1'b0, 9'h005, 32'h0000_FFFF, 32'h0, 1'b1);
        doAccess("t4_lw0", 1'b0, 1'b0, SZ_W, 1'b0, 9'h000, 32'h0, 32'h1122_3344, 1'b0);
        doAccess("t4_lw4", 1'b0, 1'b0, SZ_W, 1'b0, 9'h004, 32'h0, 32'h5566_7788, 1'b0);
        doAccess("t4_sh6", 1'b0, 1'b1, SZ_H, 1'b0, 9'h006, 32'h0000_CAFE, 32'h0, 1'b0);
        doAccess("t4_lw4b", 1'b0, 1'b0, SZ_W, 1'b0, 9'h004, 32'h0, 32'hCAFE_7788, 1'b0);

        $display("[TB] reset during wait states");
        doAccess("t5_pre_sw", 1'b1, 1'b1, SZ_W, 1'b0, 9'h010, 32'h0000_0028, 32'h0, 1'b0);
        doAccess("t5_pre_lw", 1'b1, 1'b0, SZ_W, 1'b0, 9'h010, 32'h0, 32'h0000_0028, 1'b0);
        @(negedge clk);
        we = 1'b1; size = SZ_W; addr = 9'h010; wdata = 32'h1234_5678; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        req3  = 1'b0;
        #1;
        checkOutput("t5_rst_rdata3", rdata3, 32'd0);
        checkOutput("t5_rst_misalign3", {31'b0, misalign3}, 32'd0);
        checkOutput("t5_rst_rdata1", rdata1, 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready3) pulses++;
        end
        checkOutput("t5_no_ready", 32'(pulses), 32'd0);
        doAccess("t5_lw_old", 1'b1, 1'b0, SZ_W, 1'b0, 9'h010, 32'h0, 32'h0000_0028, 1'b0);

        $display("[TB] top of memory and back-to-back");
        doAccess("t6_sw0",  1'b0, 1'b1, SZ_W, 1'b0, 9'h000, 32'h0102_0304, 32'h0, 1'b0);
        doAccess("t6_swtop", 1'b0, 1'b1, SZ_W, 1'b0, 9'h1FC, 32'hA5A5_A5A5, 32'h0, 1'b0);
        doAccess("t6_lwtop", 1'b0, 1'b0, SZ_W, 1'b0, 9'h1FC, 32'h0, 32'hA5A5_A5A5, 1'b0);
        doAccess("t6_lw0",  1'b0, 1'b0, SZ_W, 1'b0, 9'h000, 32'h0, 32'h0102_0304, 1'b0);

        @(negedge clk);
        we = 1'b0; size = SZ_W; uns = 1'b0; addr = 9'h1FC; req1 = 1'b1;
        first = -1; second = -1; cyc = 0;
        while (second < 0 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ready1) begin
                if (first < 0) first = cyc;
                else           second = cyc;
            end
        end
        req1 = 1'b0;
        checkOutput("t6_b2b_gap", 32'(second - first), 32'd3);
        checkOutput("t6_b2b_rdata", rdata1, 32'hA5A5_A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
